// File: rtl/mlp_seq_core.sv
// mlp_seq_core: time-multiplexed N_IN-N_HID-1 MLP on one signed MAC.
// Weights and biases live in a register file written over the cfg port.
module mlp_seq_core #(
  parameter int N_IN       = 2,
  parameter int N_HID      = 3,
  parameter int IN_WIDTH   = 1,
  parameter int W_WIDTH    = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [ADDR_WIDTH-1:0]    cfg_addr,
  input  logic [W_WIDTH-1:0]       cfg_wdata,
  output logic                     cfg_drop,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*IN_WIDTH-1:0] in_vec,
  input  logic                     act_relu,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     final_out,
  output logic [ACC_WIDTH-1:0]     score
);

  localparam int NWORDS = N_HID*(N_IN+2)+1;
  localparam int AI     = $clog2(NWORDS);
  localparam int XW     = (IN_WIDTH > W_WIDTH-1) ?
                          IN_WIDTH : W_WIDTH-1;
  localparam int HW     = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int OBASE  = N_HID*(N_IN+1);
  localparam int MINACC = 2*W_WIDTH+IN_WIDTH+
                          $clog2(N_HID+N_IN+1);
  localparam logic [ADDR_WIDTH:0] NW =
    (ADDR_WIDTH+1)'(NWORDS);

  if (ACC_WIDTH < MINACC) begin : g_acc_chk
    $error("mlp_seq_core: ACC_WIDTH too small");
  end
  if ((64'd1 << ADDR_WIDTH) < 64'(NWORDS)) begin : g_addr_chk
    $error("mlp_seq_core: ADDR_WIDTH too small");
  end

  typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

  state_t                  state;
  logic [W_WIDTH-1:0]      wmem [NWORDS];
  logic [N_IN*IN_WIDTH-1:0] xcap;
  logic                    relu;
  logic [W_WIDTH-2:0]      hid [N_HID];
  logic [HW-1:0]           h;
  logic [IW-1:0]           i;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] base;
  logic [AI-1:0]           w_idx;
  logic [AI-1:0]           b_idx;
  logic [XW-1:0]           x;
  logic [W_WIDTH-1:0]      w;
  logic [W_WIDTH-1:0]      b;
  logic                    first;
  logic                    last_i;
  logic                    last_h;
  logic                    pos;
  logic [W_WIDTH-2:0]      act;
  logic                    cfg_ok;

  assign last_i = (i == IW'(N_IN-1));
  assign last_h = (h == HW'(N_HID-1));

  // HID walks neuron h / input i; OUT reuses h over hidden values
  always_comb begin
    w_idx = '0;
    b_idx = '0;
    x     = '0;
    first = 1'b0;
    if (state == OUT) begin
      w_idx = AI'(OBASE + int'(h));
      b_idx = AI'(OBASE + N_HID);
      x     = XW'(hid[h]);
      first = (h == '0);
    end else begin
      w_idx = AI'(int'(h)*(N_IN+1) + int'(i));
      b_idx = AI'(int'(h)*(N_IN+1) + N_IN);
      x     = XW'(xcap[int'(i)*IN_WIDTH +: IN_WIDTH]);
      first = (i == '0);
    end
  end

  always_comb begin
    w    = wmem[w_idx];
    b    = wmem[b_idx];
    prod = $signed({{(ACC_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w}) *
           $signed({{(ACC_WIDTH-XW){1'b0}}, x});
    base = first ?
           $signed({{(ACC_WIDTH-W_WIDTH){b[W_WIDTH-1]}}, b}) :
           acc;
    acc_next = base + prod;
    pos      = !acc_next[ACC_WIDTH-1] && (|acc_next);
    act      = '0;
    if (pos) begin
      if (!relu) begin
        act = (W_WIDTH-1)'(1);
      end else if (|acc_next[ACC_WIDTH-1:W_WIDTH-1]) begin
        act = '1;
      end else begin
        act = acc_next[W_WIDTH-2:0];
      end
    end
  end

  assign in_ready = reset && (state == IDLE);
  assign cfg_ok   = ({1'b0, cfg_addr} < NW) &&
                    ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wmem      <= '{default: '0};
      hid       <= '{default: '0};
      xcap      <= '0;
      relu      <= 1'b0;
      h         <= '0;
      i         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      final_out <= 1'b0;
      score     <= '0;
      cfg_drop  <= 1'b0;
    end else begin
      cfg_drop <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        wmem[AI'(cfg_addr)] <= cfg_wdata;
      end
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xcap  <= in_vec;
            relu  <= act_relu;
            h     <= '0;
            i     <= '0;
            state <= HID;
          end
        end
        HID: begin
          acc <= acc_next;
          if (last_i) begin
            hid[h] <= act;
            i      <= '0;
            if (last_h) begin
              h     <= '0;
              state <= OUT;
            end else begin
              h <= h + HW'(1);
            end
          end else begin
            i <= i + IW'(1);
          end
        end
        OUT: begin
          acc <= acc_next;
          if (last_h) begin
            score     <= acc_next;
            final_out <= pos;
            out_valid <= 1'b1;
            h         <= '0;
            state     <= DONE;
          end else begin
            h <= h + HW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_core.sv
// tb_mlp_seq_core: directed vectors for the XOR net plus
// handshake, config-guard, reset and wide-parameter sequences.
module tb_mlp_seq_core;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_drop;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_vec;
  logic        act_relu;
  logic        out_valid;
  logic        out_ready;
  logic        final_out;
  logic [23:0] score;

  logic        cfg_we2;
  logic [4:0]  cfg_addr2;
  logic [7:0]  cfg_wdata2;
  logic        cfg_drop2;
  logic        in_valid2;
  logic        in_ready2;
  logic [15:0] in_vec2;
  logic        act_relu2;
  logic        out_valid2;
  logic        out_ready2;
  logic        final_out2;
  logic [23:0] score2;

  int checks = 0;
  int errors = 0;

  mlp_seq_core dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_drop(cfg_drop),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .act_relu(act_relu),
    .out_valid(out_valid), .out_ready(out_ready),
    .final_out(final_out), .score(score)
  );

  mlp_seq_core #(
    .N_IN(4), .N_HID(5), .IN_WIDTH(4)
  ) dut2 (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we2), .cfg_addr(cfg_addr2),
    .cfg_wdata(cfg_wdata2), .cfg_drop(cfg_drop2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_vec(in_vec2), .act_relu(act_relu2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .final_out(final_out2), .score(score2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic x0;
    logic x1;
    logic relu;
    int   sc;
    int   fin;
  } vec_t;

  vec_t tbl [5];
  int   xor_w [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  task automatic cfg_write(input int a, input int v);
    cfg_we    = 1'b1;
    cfg_addr  = 5'(a);
    cfg_wdata = 8'(v);
    tick();
    cfg_we    = 1'b0;
    check("cfg_drop_ok", int'(cfg_drop), 0);
  endtask

  task automatic cfg_write2(input int a, input int v);
    cfg_we2    = 1'b1;
    cfg_addr2  = 5'(a);
    cfg_wdata2 = 8'(v);
    tick();
    cfg_we2    = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ov_clear", int'(out_valid), 0);
    check("ir_back", int'(in_ready), 1);
  endtask

  task automatic accept(input logic x0, input logic x1,
                        input logic relu);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ir_before", int'(in_ready), 1);
    in_vec   = {x1, x0};
    act_relu = relu;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_vec   = ~{x1, x0};
    act_relu = ~relu;
  endtask

  task automatic run(input logic x0, input logic x1,
                     input logic relu, input int sc,
                     input int fin);
    int n;
    accept(x0, x1, relu);
    wait_out(n);
    check("latency", n, 9);
    check("score", int'($signed(score)), sc);
    check("final_out", int'(final_out), fin);
    release_out();
  endtask

  initial begin
    int n;
    bit seen;
    tbl[0] = '{1'b0, 1'b0, 1'b0, -1, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 126, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 127, 1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, -1, 0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 0, 0};
    xor_w = '{-110, 110, 110, -56, 14, -15,
              -128, 127, 0, -128, -15, 127, 127};

    reset = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_vec = '0; act_relu = 1'b0;
    out_ready = 1'b0;
    cfg_we2 = 1'b0; cfg_addr2 = '0; cfg_wdata2 = '0;
    in_valid2 = 1'b0; in_vec2 = '0; act_relu2 = 1'b0;
    out_ready2 = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_final", int'(final_out), 0);
    check("rst_score", int'(score), 0);
    check("rst_cfg_drop", int'(cfg_drop), 0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", int'(in_ready), 1);

    for (int k = 0; k < 13; k++) cfg_write(k, xor_w[k]);

    for (int k = 0; k < 5; k++) begin
      run(tbl[k].x0, tbl[k].x1, tbl[k].relu,
          tbl[k].sc, tbl[k].fin);
    end

    // result held while consumer stalls
    accept(1'b0, 1'b1, 1'b0);
    wait_out(n);
    check("hs_latency", n, 9);
    for (int k = 0; k < 5; k++) begin
      check("hs_score", int'($signed(score)), 126);
      check("hs_in_ready", int'(in_ready), 0);
      check("hs_out_valid", int'(out_valid), 1);
      tick();
    end
    release_out();

    // write during HID is rejected
    accept(1'b1, 1'b0, 1'b0);
    tick();
    cfg_we = 1'b1; cfg_addr = 5'd4; cfg_wdata = 8'd127;
    tick();
    cfg_we = 1'b0;
    check("drop_hid", int'(cfg_drop), 1);
    tick();
    check("drop_hid_end", int'(cfg_drop), 0);
    wait_out(n);
    check("guard_score", int'($signed(score)), 127);
    release_out();
    cfg_we = 1'b1; cfg_addr = 5'd20; cfg_wdata = 8'd127;
    tick();
    cfg_we = 1'b0;
    check("drop_range", int'(cfg_drop), 1);
    tick();
    check("drop_range_end", int'(cfg_drop), 0);
    run(1'b0, 1'b1, 1'b0, 126, 1);

    // reset in the middle of a computation
    accept(1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("mid_in_ready", int'(in_ready), 0);
    check("mid_out_valid", int'(out_valid), 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("mid_rel_ready", int'(in_ready), 1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_result", int'(seen), 0);
    run(1'b1, 1'b1, 1'b0, 0, 0);

    // wide configuration
    for (int hh = 0; hh < 5; hh++) begin
      for (int ii = 0; ii < 4; ii++) cfg_write2(hh*5+ii, 1);
      cfg_write2(hh*5+4, 0);
      cfg_write2(25+hh, 1);
    end
    cfg_write2(30, 0);
    check("w_in_ready", int'(in_ready2), 1);
    in_vec2 = 16'hFFFF; act_relu2 = 1'b0; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 100) begin
      tick();
      n++;
    end
    check("w_latency", n, 25);
    check("w_score", int'($signed(score2)), 5);
    check("w_final", int'(final_out2), 1);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("w_ir_back", int'(in_ready2), 1);
    act_relu2 = 1'b1; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 100) begin
      tick();
      n++;
    end
    check("w_relu_lat", n, 25);
    check("w_relu_score", int'($signed(score2)), 300);
    check("w_relu_final", int'(final_out2), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_seq_core.md
Name: mlp_seq_core

Overview:
- Parametrised, time-multiplexed successor to the fixed 2-3-1 XOR MLP: N_IN inputs, N_HID hidden neurons and one output neuron.
- Uses a single signed MAC, one product per clock.
- Weights and biases live in an internal register file loaded over a config write port, so a new network needs no new port list.
- Adds valid/ready handshakes, a selectable hidden activation (step or clipped ReLU), and a raw output score alongside the 1-bit decision.

Parameters:
- N_IN, 2, number of network inputs
- N_HID, 3, number of hidden neurons
- IN_WIDTH, 1, width of each unsigned input element
- W_WIDTH, 8, signed weight/bias width
- ACC_WIDTH, 24, signed accumulator width; must be >= 2*W_WIDTH+IN_WIDTH+$clog2(N_HID+N_IN+1). Elaboration error if violated.
- ADDR_WIDTH, 5, config address width; must cover N_HID*(N_IN+2)+1 words

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, asynchronous, active-low reset
- cfg_we, input, 1, config write strobe
- cfg_addr, input, ADDR_WIDTH, weight/bias word address
- cfg_wdata, input, W_WIDTH, signed weight/bias value
- cfg_drop, output, 1, one-cycle pulse: write rejected
- in_valid, input, 1, input vector valid
- in_ready, output, 1, core can accept a vector
- in_vec, input, N_IN*IN_WIDTH, inputs; element i at [i*IN_WIDTH +: IN_WIDTH], unsigned
- act_relu, input, 1, 0 = step hidden activation, 1 = clipped ReLU; sampled at accept
- out_valid, output, 1, result valid
- out_ready, input, 1, consumer takes result
- final_out, output, 1, 1 iff score > 0
- score, output, ACC_WIDTH, signed output-neuron sum

Behaviour:
- Reset (reset==0, async):
  - FSM goes to IDLE.
  - All weights/biases, accumulator, captured inputs and hidden registers go to 0.
  - Outputs: in_ready=0 while reset asserted, 1 on the first cycle after release; out_valid=0, final_out=0, score=0, cfg_drop=0.
  - Reset mid-computation aborts the computation; no result is produced.
- Config address map. Hidden neuron h occupies base h*(N_IN+1):
  - words base..base+N_IN-1 hold weights for inputs 0..N_IN-1.
  - word base+N_IN holds bias_h.
  - Output weights for hidden h sit at N_HID*(N_IN+1)+h; output bias at N_HID*(N_IN+2).
  - Defaults give 13 words (0..12).
- Config write rules:
  - Writes take effect on the clock edge only in IDLE or DONE.
  - A write in HID/OUT, or to an address beyond the map, is discarded and pulses cfg_drop for one cycle.
- FSM states and transitions:
  - IDLE: in_ready=1. in_valid&&in_ready captures in_vec and act_relu, then goes to HID.
  - HID: N_HID*N_IN cycles; the MAC visits neuron h, input i in order.
    - First product of a neuron: acc <= sext(bias_h) + w*x. Otherwise acc <= acc + w*x.
    - Products are signed weight × zero-extended input.
    - On the last product of neuron h, hid[h] <= act(acc_next).
    - step: 1 if acc_next>0 else 0. ReLU: 0 if acc_next<=0, else min(acc_next, 2^(W_WIDTH-1)-1).
  - OUT: N_HID cycles of the same scheme on hid[h] (unsigned) × output weight, seeded with the output bias. The last cycle registers score and final_out, then goes to DONE.
  - DONE: out_valid=1; score/final_out held stable. out_ready returns to IDLE the next cycle. in_ready=0 in DONE, so results are never lost.
- Latency: out_valid rises N_HID*(N_IN+1) edges after the accept edge (defaults: 9).
  - Peak throughput is one vector per N_HID*(N_IN+1)+2 cycles.
- Captured inputs are immune to in_vec changes after accept.
- The weight register file is not cleared between inferences.

Test Plan:
- XOR load, step mode. Load (addr:value) 0:-110, 1:110, 2:110, 3:-56, 4:14, 5:-15, 6:-128, 7:127, 8:0, 9:-128, 10:-15, 11:127, 12:127. Run vectors (0,0), (0,1), (1,0), (1,1) -> final_out 0,1,1,0; score -1,126,127,-1.
- Latency/handshake: accept (0,1) at edge T -> out_valid at T+9. Hold out_ready=0 for 5 cycles -> score=126 stable and in_ready=0 throughout. out_ready=1 -> in_ready=1 next cycle.
- ReLU mode: XOR weights, act_relu=1, vector (0,1). h1 clips 220->127, h3=127 -> score=0, final_out=0.
- Config guard: cfg_we to addr 4 during HID -> cfg_drop pulse, weight unchanged, (1,0) result still score 127. Write to addr 20 in IDLE -> cfg_drop pulse.
- Reset mid-run: assert reset 4 cycles after accept -> out_valid never rises. After release, in_ready=1 and a rerun with zero weights gives score=0, final_out=0.
- Parameter sweep N_IN=4, N_HID=5, IN_WIDTH=4, all weights=1, biases=0, inputs all 15, step mode -> each hidden=1, score=5, final_out=1, latency 25.
